// File: rtl/adder_vector_checker_if.sv
// rtl/adder_vector_checker_if.sv - vector memory, adder and status signals of the adder vector checker
interface adder_vector_checker_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) ();
  logic              start;
  logic [ADDR_W-1:0] vec_addr;
  logic [WIDTH-1:0]  vec_x;
  logic [WIDTH-1:0]  vec_y;
  logic              vec_c;
  logic [WIDTH-1:0]  op_x;
  logic [WIDTH-1:0]  op_y;
  logic              op_cin;
  logic [WIDTH-1:0]  add_s;
  logic              add_cout;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   pass_cnt;
  logic [ADDR_W:0]   fail_cnt;
  logic              fail_seen;
  logic [ADDR_W-1:0] first_fail;

  // Checker side: reads vectors and adder results, drives operands and status.
  modport slave (
    input  start, vec_x, vec_y, vec_c, add_s, add_cout,
    output vec_addr, op_x, op_y, op_cin, busy, done,
           pass_cnt, fail_cnt, fail_seen, first_fail
  );

  // Environment side: vector memory, adder under test and run control.
  modport master (
    output start, vec_x, vec_y, vec_c, add_s, add_cout,
    input  vec_addr, op_x, op_y, op_cin, busy, done,
           pass_cnt, fail_cnt, fail_seen, first_fail
  );
endinterface

// File: rtl/adder_vector_checker.sv
// rtl/adder_vector_checker.sv - clocked vector-driven checker for a ripple-carry adder
module adder_vector_checker #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_vector_checker_if.slave bus
);
  localparam int CW    = ADDR_W + 1;
  localparam int SCNTW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SCNTW-1:0] settle_cnt;
  logic             settle_last;
  logic             row_last;
  logic [WIDTH:0]   golden;
  logic             match;

  assign settle_last = (settle_cnt == SCNTW'(SETTLE_CYCLES - 1));
  assign row_last    = (bus.vec_addr == ADDR_W'(DEPTH - 1));
  assign golden      = {1'b0, bus.op_x} + {1'b0, bus.op_y} + {{WIDTH{1'b0}}, bus.op_cin};
  assign match       = ({bus.add_cout, bus.add_s} == golden);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state selection and the busy/done flags derived from the current state.
  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_LOAD;
      S_LOAD:   begin bus.busy = 1'b1; state_d = S_SETTLE; end
      S_SETTLE: begin bus.busy = 1'b1; if (settle_last) state_d = S_CHECK; end
      S_CHECK:  begin bus.busy = 1'b1; state_d = row_last ? S_DONE : S_LOAD; end
      S_DONE:   begin bus.done = 1'b1; if (bus.start) state_d = S_LOAD; end
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: row address, held operands, settle timer and result tallies.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vec_addr   <= '0;
      bus.op_x       <= '0;
      bus.op_y       <= '0;
      bus.op_cin     <= 1'b0;
      bus.pass_cnt   <= '0;
      bus.fail_cnt   <= '0;
      bus.fail_seen  <= 1'b0;
      bus.first_fail <= '0;
      settle_cnt     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            bus.vec_addr   <= '0;
            bus.pass_cnt   <= '0;
            bus.fail_cnt   <= '0;
            bus.fail_seen  <= 1'b0;
            bus.first_fail <= '0;
          end
        end
        S_LOAD: begin
          bus.op_x   <= bus.vec_x;
          bus.op_y   <= bus.vec_y;
          bus.op_cin <= bus.vec_c;
          settle_cnt <= '0;
        end
        S_SETTLE: settle_cnt <= settle_cnt + SCNTW'(1);
        S_CHECK: begin
          if (match) begin
            bus.pass_cnt <= bus.pass_cnt + CW'(1);
          end else begin
            bus.fail_cnt <= bus.fail_cnt + CW'(1);
            // Only the first mismatch of a run records its row.
            if (!bus.fail_seen) begin
              bus.fail_seen  <= 1'b1;
              bus.first_fail <= bus.vec_addr;
            end
          end
          if (!row_last) bus.vec_addr <= bus.vec_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_vector_checker.sv
// tb/tb_adder_vector_checker.sv - self-checking bench for adder_vector_checker
module tb_adder_vector_checker;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int SETTLE = 8;
  localparam int ROW_T  = SETTLE + 2;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        c;
    logic [32:0] sum;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fault_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  vec_t        tbl [DEPTH];
  logic [31:0] mem_x [DEPTH];
  logic [31:0] mem_y [DEPTH];
  logic        mem_c [DEPTH];
  logic [32:0] sum_full;

  adder_vector_checker_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) vi ();

  adder_vector_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vi.slave)
  );

  always #5 clk = ~clk;

  // Vector memory and adder model (optionally with sum bit 5 stuck at 0).
  assign vi.vec_x    = mem_x[vi.vec_addr];
  assign vi.vec_y    = mem_y[vi.vec_addr];
  assign vi.vec_c    = mem_c[vi.vec_addr];
  assign sum_full    = {1'b0, vi.op_x} + {1'b0, vi.op_y} + {32'd0, vi.op_cin};
  assign vi.add_s    = fault_en ? (sum_full[31:0] & ~32'h20) : sum_full[31:0];
  assign vi.add_cout = sum_full[32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"}, 64'(vi.busy), 0);
    check({tag, " done"}, 64'(vi.done), 0);
    check({tag, " vec_addr"}, 64'(vi.vec_addr), 0);
    check({tag, " ops"}, {vi.op_x, vi.op_y} | 64'(vi.op_cin), 0);
    check({tag, " counts"}, 64'({vi.pass_cnt, vi.fail_cnt}), 0);
    check({tag, " fail info"}, 64'({vi.fail_seen, vi.first_fail}), 0);
  endtask

  task automatic load_table();
    for (int i = 0; i < DEPTH; i++) begin
      mem_x[i] = tbl[i].x;
      mem_y[i] = tbl[i].y;
      mem_c[i] = tbl[i].c;
    end
  endtask

  // Row-by-row run of the table with exact cycle accounting.
  task automatic run_table(input logic faulty, input logic mid_start);
    int exp_pass;
    int exp_fail;
    fault_en = faulty;
    load_table();
    exp_pass = 0;
    exp_fail = 0;
    vi.start = 1'b1;
    tick();
    vi.start = 1'b0;
    check("start busy", 64'(vi.busy), 1);
    check("start done", 64'(vi.done), 0);
    check("start counts clear", 64'({vi.pass_cnt, vi.fail_cnt}), 0);
    for (int r = 0; r < DEPTH; r++) begin
      for (int k = 1; k <= ROW_T; k++) begin
        vi.start = (mid_start && r == 6 && k == 3);
        tick();
        if (k == 1) check($sformatf("row%0d addr", r), 64'(vi.vec_addr), 64'(r));
        if (k < ROW_T && (r == 9 || k == 5))
          check($sformatf("row%0d ops k%0d", r, k), {vi.op_x, vi.op_y ^ {31'd0, vi.op_cin}},
                {tbl[r].x, tbl[r].y ^ {31'd0, tbl[r].c}});
        if (k == ROW_T - 1 && r == DEPTH - 1) check("done early", 64'(vi.done), 0);
      end
      if (!faulty || !tbl[r].sum[5]) exp_pass++;
      else exp_fail++;
      check($sformatf("row%0d pass_cnt", r), 64'(vi.pass_cnt), 64'(exp_pass));
      check($sformatf("row%0d fail_cnt", r), 64'(vi.fail_cnt), 64'(exp_fail));
    end
    vi.start = 1'b0;
    check("done at 160", 64'(vi.done), 1);
    check("busy at done", 64'(vi.busy), 0);
  endtask

  // Random vectors checked against an arithmetic model of the whole run.
  task automatic run_random();
    int exp_pass, exp_fail, exp_first, cycles;
    logic [32:0] s;
    fault_en = 1'($urandom);
    exp_pass = 0; exp_fail = 0; exp_first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      mem_x[i] = $urandom;
      mem_y[i] = $urandom;
      mem_c[i] = 1'($urandom);
      s = {1'b0, mem_x[i]} + {1'b0, mem_y[i]} + {32'd0, mem_c[i]};
      if (fault_en && s[5]) begin
        exp_fail++;
        if (exp_first < 0) exp_first = i;
      end else begin
        exp_pass++;
      end
    end
    vi.start = 1'b1;
    tick();
    vi.start = 1'b0;
    cycles = 0;
    while (!vi.done && cycles < 400) begin
      tick();
      cycles++;
    end
    check("rand latency", 64'(cycles), 64'(DEPTH * ROW_T));
    check("rand pass_cnt", 64'(vi.pass_cnt), 64'(exp_pass));
    check("rand fail_cnt", 64'(vi.fail_cnt), 64'(exp_fail));
    check("rand fail_seen", 64'(vi.fail_seen), 64'(exp_first >= 0));
    check("rand first_fail", 64'(vi.first_fail), exp_first >= 0 ? 64'(exp_first) : 64'd0);
  endtask

  initial begin
    tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_00000000};
    tbl[1]  = '{32'h00000000, 32'h00000000, 1'b1, 33'h0_00000001};
    tbl[2]  = '{32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000};
    tbl[3]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 33'h0_FFFFFFFF};
    tbl[4]  = '{32'h00000010, 32'h00000008, 1'b0, 33'h0_00000018};
    tbl[5]  = '{32'h12340000, 32'h00005600, 1'b1, 33'h0_12345601};
    tbl[6]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 33'h0_00010000};
    tbl[7]  = '{32'hAAAA0000, 32'h55550000, 1'b1, 33'h0_FFFF0001};
    tbl[8]  = '{32'hF0000000, 32'h20000000, 1'b0, 33'h1_10000000};
    tbl[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF};
    tbl[10] = '{32'h00000001, 32'h00000002, 1'b1, 33'h0_00000004};
    tbl[11] = '{32'h0000000F, 32'h00000010, 1'b0, 33'h0_0000001F};
    tbl[12] = '{32'h40000000, 32'h40000000, 1'b1, 33'h0_80000001};
    tbl[13] = '{32'hFFFFFF00, 32'h00000100, 1'b0, 33'h1_00000000};
    tbl[14] = '{32'h00000003, 32'h00000004, 1'b0, 33'h0_00000007};
    tbl[15] = '{32'hDEAD0000, 32'h00001E00, 1'b0, 33'h0_DEAD1E00};
    load_table();
    vi.start = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle_zero("reset");

    run_table(1'b0, 1'b0);
    check("ideal fail_seen", 64'(vi.fail_seen), 0);

    run_table(1'b0, 1'b1);
    check("midstart pass_cnt", 64'(vi.pass_cnt), 16);

    run_table(1'b1, 1'b0);
    check("fault first_fail", 64'(vi.first_fail), 3);
    check("fault fail_seen", 64'(vi.fail_seen), 1);

    fault_en = 1'b0;
    vi.start = 1'b1;
    tick();
    vi.start = 1'b0;
    for (int i = 0; i < 10 * ROW_T + 2; i++) tick();
    check("pre-reset busy", 64'(vi.busy), 1);
    check("pre-reset row", 64'(vi.vec_addr), 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("midrun reset");

    run_table(1'b0, 1'b0);
    for (int n = 0; n < 4; n++) run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
